// File: rtl/uncached_store_tracker_if.sv
// Uncached store tracker bus bundle.
//   st_*   : uncached store request from the dcache bypass path
//   mem_*  : forwarded request to the AXI4 adapter
//   b_*    : AXI B responses (always consumed)
//   ld_*   : load alias check
//   fence_*: drain handshake
//   err_*, outstanding_o, b_unexpected_o : status
// slave = the tracker, master = the surrounding dcache/adapter side.
interface uncached_store_tracker_if #(
  parameter int AddrWidth = 64,
  parameter int CntWidth  = 3
);
  logic                 st_valid_i;
  logic                 st_ready_o;
  logic [AddrWidth-1:0] st_addr_i;
  logic [1:0]           st_size_i;
  logic                 mem_valid_o;
  logic                 mem_ready_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [1:0]           mem_size_o;
  logic                 b_valid_i;
  logic                 b_error_i;
  logic [AddrWidth-1:0] ld_addr_i;
  logic                 ld_conflict_o;
  logic                 fence_i;
  logic                 fence_done_o;
  logic [CntWidth-1:0]  outstanding_o;
  logic                 err_valid_o;
  logic [AddrWidth-1:0] err_addr_o;
  logic                 b_unexpected_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_size_i, mem_ready_i, b_valid_i, b_error_i,
           ld_addr_i, fence_i,
    output st_ready_o, mem_valid_o, mem_addr_o, mem_size_o, ld_conflict_o,
           fence_done_o, outstanding_o, err_valid_o, err_addr_o, b_unexpected_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_size_i, mem_ready_i, b_valid_i, b_error_i,
           ld_addr_i, fence_i,
    input  st_ready_o, mem_valid_o, mem_addr_o, mem_size_o, ld_conflict_o,
           fence_done_o, outstanding_o, err_valid_o, err_addr_o, b_unexpected_o
  );
endinterface

// File: rtl/uncached_store_tracker.sv
// Uncached store tracker.
// Admits up to MaxOutstanding uncached stores toward the AXI adapter, keeps
// each address in an in-order table until its B response returns, flags
// loads hitting an in-flight store's 8-byte granule, drains on fence and
// reports errored stores.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   bus          : uncached_store_tracker_if.slave (store/mem/B/load/fence/status)

// One table slot: address, valid, and the load-granule compare.
module uncached_store_entry #(
  parameter int AddrWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-4:0] ld_gran_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 valid_o,
  output logic                 hit_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      addr_o  <= '0;
    end else if (push_i) begin
      valid_o <= 1'b1;
      addr_o  <= addr_i;
    end else if (pop_i) begin
      valid_o <= 1'b0;
    end
  end

  // Registered valid: a slot popped this cycle still hits, one pushed this
  // cycle hits only from the next.
  assign hit_o = valid_o && (addr_o[AddrWidth-1:3] == ld_gran_i);
endmodule

module uncached_store_tracker #(
  parameter int MaxOutstanding = 7,
  parameter int AddrWidth      = 64,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input logic clk_i,
  input logic rst_i,
  uncached_store_tracker_if.slave bus
);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                                  state_q, state_d;
  logic   [CntWidth-1:0]                   count_q;
  logic   [PtrW-1:0]                       wptr_q, rptr_q;
  logic                                    accept_ok, fence_done;
  logic                                    push, pop;
  logic   [MaxOutstanding-1:0]             ent_valid, ent_hit, ent_push, ent_pop;
  logic   [MaxOutstanding-1:0][AddrWidth-1:0] ent_addr;
  logic                                    err_valid_q, unexp_q;
  logic   [AddrWidth-1:0]                  err_addr_q;
  logic                                    unused_ld_lsb;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.fence_i) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs. Gate uses the registered count only, so a B in the same
  // cycle does not free a slot until the next one.
  always_comb begin
    accept_ok  = 1'b0;
    fence_done = 1'b0;
    case (state_q)
      RUN:     accept_ok  = (count_q < CntWidth'(MaxOutstanding));
      DRAIN:   fence_done = (count_q == '0);
      default: ;
    endcase
  end

  // Zero-latency forwarding; rst_i also masks the handshake so outputs
  // read as idle while reset is held.
  assign bus.st_ready_o  = !rst_i && bus.mem_ready_i && accept_ok;
  assign bus.mem_valid_o = !rst_i && bus.st_valid_i  && accept_ok;
  assign bus.mem_addr_o  = bus.st_addr_i;
  assign bus.mem_size_o  = bus.st_size_i;

  assign push = bus.st_valid_i && bus.st_ready_o;
  assign pop  = bus.b_valid_i && (count_q != '0);

  for (genvar g = 0; g < MaxOutstanding; g++) begin : g_ent
    assign ent_push[g] = push && (wptr_q == PtrW'(g));
    assign ent_pop[g]  = pop  && (rptr_q == PtrW'(g));
    uncached_store_entry #(.AddrWidth(AddrWidth)) u_ent (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (ent_push[g]),
      .pop_i     (ent_pop[g]),
      .addr_i    (bus.st_addr_i),
      .ld_gran_i (bus.ld_addr_i[AddrWidth-1:3]),
      .addr_o    (ent_addr[g]),
      .valid_o   (ent_valid[g]),
      .hit_o     (ent_hit[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Error pulse lasts one cycle; the address is held until the next error.
  // B with an empty table never pops, so it cannot raise a pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      unexp_q     <= 1'b0;
    end else begin
      err_valid_q <= pop && bus.b_error_i;
      if (pop && bus.b_error_i) err_addr_q <= ent_addr[rptr_q];
      if (bus.b_valid_i && count_q == '0) unexp_q <= 1'b1;
    end
  end

  assign bus.ld_conflict_o  = |ent_hit;
  assign bus.fence_done_o   = fence_done;
  assign bus.outstanding_o  = count_q;
  assign bus.err_valid_o    = err_valid_q;
  assign bus.err_addr_o     = err_addr_q;
  assign bus.b_unexpected_o = unexp_q;

  // Granule check ignores the byte offset within 8 bytes.
  assign unused_ld_lsb = ^{bus.ld_addr_i[2:0], ent_valid};
endmodule
